// File: rtl/ula_pkg.sv
// Shared opcode map and sizing for the ula_unit ALU.
// ULA_OVERFLOW_FLAG_EN adds a registered signed-overflow flag.
package ula_pkg;
    localparam int OPW       = 4;
    localparam int WIDTH_DEF = 8;

    localparam logic [OPW-1:0] OP_ADD   = 4'h0;
    localparam logic [OPW-1:0] OP_SUB   = 4'h1;
    localparam logic [OPW-1:0] OP_AND   = 4'h2;
    localparam logic [OPW-1:0] OP_OR    = 4'h3;
    localparam logic [OPW-1:0] OP_XOR   = 4'h4;
    localparam logic [OPW-1:0] OP_MUL2  = 4'h5;
    localparam logic [OPW-1:0] OP_DIV2  = 4'h6;
    localparam logic [OPW-1:0] OP_NOT   = 4'h7;
    localparam logic [OPW-1:0] OP_PASSB = 4'h8;
    localparam logic [OPW-1:0] OP_INC   = 4'h9;
    localparam logic [OPW-1:0] OP_DEC   = 4'hA;
endpackage

// File: rtl/ula_if.sv
// Operand/opcode bus into the ALU and registered result/flags back out.
// ULA_OVERFLOW_FLAG_EN adds overflow_flag to the bus.
interface ula_if
    import ula_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] result;
    logic             zero_flag;
    logic             carrier_flag;
    logic             negative_flag;
`ifdef ULA_OVERFLOW_FLAG_EN
    logic             overflow_flag;
`endif

    modport master (
        output val_a, val_b, op,
`ifdef ULA_OVERFLOW_FLAG_EN
        input  overflow_flag,
`endif
        input  result, zero_flag, carrier_flag, negative_flag
    );

    modport slave (
        input  val_a, val_b, op,
`ifdef ULA_OVERFLOW_FLAG_EN
        output overflow_flag,
`endif
        output result, zero_flag, carrier_flag, negative_flag
    );
endinterface

// File: rtl/ula_datapath.sv
// Combinational ALU core: next result, carry and (ULA_OVERFLOW_FLAG_EN)
// signed overflow from operands and opcode.
module ula_datapath
    import ula_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [OPW-1:0]   i_op,
`ifdef ULA_OVERFLOW_FLAG_EN
    output logic             o_ovf,
`endif
    output logic [WIDTH-1:0] o_res,
    output logic             o_carry
);
    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] w_one;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic [WIDTH:0] w_inc;
    logic [WIDTH:0] w_dec;

    assign w_one  = {{WIDTH{1'b0}}, 1'b1};
    // Bit WIDTH of each extended op is the carry or the borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc  = {1'b0, i_a} + w_one;
    assign w_dec  = {1'b0, i_a} - w_one;

    always_comb begin
        o_res   = '0;
        o_carry = 1'b0;
        unique case (1'b1)
            (i_op == OP_ADD): begin
                o_res   = w_sum[MSB:0];
                o_carry = w_sum[WIDTH];
            end
            (i_op == OP_SUB): begin
                o_res   = w_diff[MSB:0];
                o_carry = w_diff[WIDTH];
            end
            (i_op == OP_AND):   o_res = i_a & i_b;
            (i_op == OP_OR):    o_res = i_a | i_b;
            (i_op == OP_XOR):   o_res = i_a ^ i_b;
            (i_op == OP_MUL2): begin
                o_res   = {i_a[MSB-1:0], 1'b0};
                o_carry = i_a[MSB];
            end
            (i_op == OP_DIV2): begin
                o_res   = {1'b0, i_a[MSB:1]};
                o_carry = i_a[0];
            end
            (i_op == OP_NOT):   o_res = ~i_a;
            (i_op == OP_PASSB): o_res = i_b;
            (i_op == OP_INC): begin
                o_res   = w_inc[MSB:0];
                o_carry = w_inc[WIDTH];
            end
            (i_op == OP_DEC): begin
                o_res   = w_dec[MSB:0];
                o_carry = w_dec[WIDTH];
            end
            default: begin
                o_res   = '0;
                o_carry = 1'b0;
            end
        endcase
    end

`ifdef ULA_OVERFLOW_FLAG_EN
    logic w_sa;
    logic w_sb;
    logic w_sr;

    assign w_sa = i_a[MSB];
    assign w_sb = i_b[MSB];
    assign w_sr = o_res[MSB];

    // INC/DEC act as ADD/SUB with a positive one as operand B.
    always_comb begin
        o_ovf = 1'b0;
        unique case (1'b1)
            (i_op == OP_ADD): o_ovf = (w_sa == w_sb) && (w_sr != w_sa);
            (i_op == OP_SUB): o_ovf = (w_sa != w_sb) && (w_sr != w_sa);
            (i_op == OP_INC): o_ovf = !w_sa && w_sr;
            (i_op == OP_DEC): o_ovf = w_sa && !w_sr;
            default:          o_ovf = 1'b0;
        endcase
    end
`endif
endmodule

// File: rtl/ula_unit.sv
// Registered 8-bit ALU: result plus zero/carry/negative flags, 1-cycle latency.
// ULA_OVERFLOW_FLAG_EN adds a registered signed-overflow flag.
module ula_unit
    import ula_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic  clk,
    input  logic  rst_n,
    ula_if.slave  bus
);
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_carry;
    logic             r_neg;

`ifdef ULA_OVERFLOW_FLAG_EN
    logic w_ovf;
    logic r_ovf;
`endif

    ula_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .i_a     (bus.val_a),
        .i_b     (bus.val_b),
        .i_op    (bus.op),
`ifdef ULA_OVERFLOW_FLAG_EN
        .o_ovf   (w_ovf),
`endif
        .o_res   (w_res),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_neg    <= 1'b0;
        end else begin
            r_result <= w_res;
            r_zero   <= (w_res == '0);
            r_carry  <= w_carry;
            r_neg    <= w_res[WIDTH-1];
        end
    end

`ifdef ULA_OVERFLOW_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ovf <= 1'b0;
        else        r_ovf <= w_ovf;
    end

    assign bus.overflow_flag = r_ovf;
`endif

    assign bus.result        = r_result;
    assign bus.zero_flag     = r_zero;
    assign bus.carrier_flag  = r_carry;
    assign bus.negative_flag = r_neg;
endmodule

// File: tb/tb_ula_unit.sv
// Self-checking bench for ula_unit: directed plan plus random ops
// against an integer reference model.
module tb_ula_unit;
    import ula_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ula_if #(.WIDTH(8)) u_if ();

    ula_unit #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    task automatic model(input int a, input int b, input int op,
                         output int res, output int c, output int v);
        int s;
        res = 0; c = 0; v = 0; s = 0;
        case (op)
            0: begin
                res = (a + b) % 256; c = (a + b > 255);
                s = sgn(a) + sgn(b);
            end
            1: begin
                res = (a - b + 256) % 256; c = (a < b);
                s = sgn(a) - sgn(b);
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 256; c = (a >= 128); end
            6: begin res = a / 2; c = a % 2; end
            7: res = 255 - a;
            8: res = b;
            9: begin
                res = (a + 1) % 256; c = (a == 255);
                s = sgn(a) + 1;
            end
            10: begin
                res = (a + 255) % 256; c = (a == 0);
                s = sgn(a) - 1;
            end
            default: res = 0;
        endcase
        if (op == 0 || op == 1 || op == 9 || op == 10)
            v = (s > 127 || s < -128);
    endtask

    task automatic apply(input string tag, input int a, input int b,
                         input int op);
        int res, c, v;
        @(negedge clk);
        u_if.val_a = 8'(a);
        u_if.val_b = 8'(b);
        u_if.op    = 4'(op);
        model(a, b, op, res, c, v);
        @(posedge clk);
        #1;
        chk({tag, ".res"}, 32'(u_if.result), 32'(res));
        chk({tag, ".z"}, 32'(u_if.zero_flag), 32'(res == 0));
        chk({tag, ".c"}, 32'(u_if.carrier_flag), 32'(c));
        chk({tag, ".n"}, 32'(u_if.negative_flag), 32'(res >= 128));
`ifdef ULA_OVERFLOW_FLAG_EN
        chk({tag, ".v"}, 32'(u_if.overflow_flag), 32'(v));
`endif
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, ".res"}, 32'(u_if.result), 32'd0);
        chk({tag, ".z"}, 32'(u_if.zero_flag), 32'd0);
        chk({tag, ".c"}, 32'(u_if.carrier_flag), 32'd0);
        chk({tag, ".n"}, 32'(u_if.negative_flag), 32'd0);
`ifdef ULA_OVERFLOW_FLAG_EN
        chk({tag, ".v"}, 32'(u_if.overflow_flag), 32'd0);
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        u_if.val_a = 8'h00;
        u_if.val_b = 8'h00;
        u_if.op    = 4'h0;
        #1;
        chk_zero_outs("rst0");
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;

        apply("add11", 8'h01, 8'h01, 0);
        apply("addFFFE", 8'hFF, 8'hFE, 0);
        apply("addFF01", 8'hFF, 8'h01, 0);
        apply("sub11", 8'h01, 8'h01, 1);
        apply("sub12", 8'h01, 8'h02, 1);
        apply("mul2_01", 8'h01, 8'h00, 5);
        apply("mul2_81", 8'h81, 8'h55, 5);
        apply("div2_02", 8'h02, 8'h00, 6);
        apply("div2_03", 8'h03, 8'hAA, 6);
        apply("and", 8'hF0, 8'h3C, 2);
        apply("not00", 8'h00, 8'h12, 7);
        apply("dec00", 8'h00, 8'h00, 10);
        apply("incFF", 8'hFF, 8'h00, 9);
        apply("passb", 8'h11, 8'h9C, 8);
        apply("op15", 8'hAB, 8'hCD, 15);
        apply("add7F01", 8'h7F, 8'h01, 0);
        apply("sub80_01", 8'h80, 8'h01, 1);

        // Asynchronous reset in mid-cycle after a nonzero result.
        apply("pre_rst", 8'h40, 8'h45, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero_outs("async_rst");
        @(posedge clk);
        #1;
        chk_zero_outs("rst_edge");
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 8'h02, 8'h03, 0);

        for (int i = 0; i < 300; i++) begin
            apply("rand", int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
